// File: rtl/cy_stream_source.sv
// cy_stream_source: valid/ready burst traffic generator.
// Emits num_bursts bursts of burst_len incrementing words starting at seed,
// separated by gap_len idle cycles. All stream outputs are registered and
// independent of i_ready combinationally.
module cy_stream_source #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [CW-1:0] i_burst_len,
  input  logic [CW-1:0] i_gap_len,
  input  logic [CW-1:0] i_num_bursts,
  input  logic [DW-1:0] i_seed,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;    // 1-based index of the presented beat
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;      // idle cycles still to spend in GAP
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;  // 1-based index of the current burst
  logic [CW-1:0] burst_len_q, burst_len_d;
  logic [CW-1:0] gap_len_q, gap_len_d;
  logic [CW-1:0] num_bursts_q, num_bursts_d;

  logic xfer;
  logic cfg_empty;
  logic final_burst;
  logic gap_expiring;

  assign xfer         = valid_q & i_ready;
  assign cfg_empty    = (i_burst_len == '0) | (i_num_bursts == '0);
  assign final_burst  = (burst_cnt_q == num_bursts_q);
  assign gap_expiring = (gap_cnt_q == CW'(1));

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      burst_len_q  <= '0;
      gap_len_q    <= '0;
      num_bursts_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_len_q  <= burst_len_d;
      gap_len_q    <= gap_len_d;
      num_bursts_q <= num_bursts_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !cfg_empty) state_d = S_BURST;
      end
      S_BURST: begin
        if (xfer && last_q) begin
          if (final_burst)             state_d = S_IDLE;
          else if (gap_len_q == '0)    state_d = S_BURST;
          else                         state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_expiring) state_d = S_BURST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and latched configuration.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    burst_len_d  = burst_len_q;
    gap_len_d    = gap_len_q;
    num_bursts_d = num_bursts_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          burst_len_d  = i_burst_len;
          gap_len_d    = i_gap_len;
          num_bursts_d = i_num_bursts;
          if (cfg_empty) begin
            done_d = 1'b1;
          end else begin
            valid_d     = 1'b1;
            data_d      = i_seed;
            last_d      = (i_burst_len == CW'(1));
            busy_d      = 1'b1;
            beat_cnt_d  = CW'(1);
            burst_cnt_d = CW'(1);
            gap_cnt_d   = '0;
          end
        end
      end
      S_BURST: begin
        if (xfer) begin
          data_d = data_q + DW'(1);
          if (!last_q) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
            last_d     = ((beat_cnt_q + CW'(1)) == burst_len_q);
          end else if (final_burst) begin
            valid_d     = 1'b0;
            last_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            beat_cnt_d  = '0;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
          end else if (gap_len_q == '0) begin
            // Back-to-back: first beat of the next burst follows immediately.
            beat_cnt_d  = CW'(1);
            last_d      = (burst_len_q == CW'(1));
            burst_cnt_d = burst_cnt_q + CW'(1);
          end else begin
            valid_d   = 1'b0;
            last_d    = 1'b0;
            gap_cnt_d = gap_len_q;
          end
        end
      end
      S_GAP: begin
        if (gap_expiring) begin
          valid_d     = 1'b1;
          beat_cnt_d  = CW'(1);
          last_d      = (burst_len_q == CW'(1));
          burst_cnt_d = burst_cnt_q + CW'(1);
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - CW'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
